fp_mult_arbiter: RTL and testbench

Shares one pipelined fp_multiplier between NUM_REQ requesters. Each requester submits a single-precision operand pair over a valid/ready handshake. A round-robin arbiter issues at most one operation per cycle. A tag pipeline tracks each in-flight operation and routes the result back to its originator, which compensates for the multiplier having no reset or valid signalling of its own. The block sits between the FP execution clients and the multiplier instance.

---
 rtl/fp_mult_arbiter.sv | 133 +++++++++++++
 tb/tb_fp_mult_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mult_arbiter.sv
// rtl/fp_mult_arbiter.sv - round-robin sharing of one pipelined fp multiplier
//
// Purpose: accepts single-precision operand pairs from NUM_REQ requesters,
// issues at most one per cycle to a shared multiplier and steers each result
// back to its originator using a tag pipeline that mirrors the multiplier.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_valid/req_ready per-requester handshake (ready is one-hot or zero)
//   req_a, req_b        packed operands, requester i at [32i+31:32i]
//   mul_a, mul_b        registered operands to the multiplier
//   mul_out             multiplier result
//   rsp_valid, rsp_data one-hot response strobe and its result
//   busy                operation in flight or any request pending
module fp_mult_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 14,
  parameter int MAX_OUT     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  output logic [31:0]            mul_a,
  output logic [31:0]            mul_b,
  input  logic [31:0]            mul_out,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [31:0]            rsp_data,
  output logic                   busy
);

  localparam int IW   = $clog2(NUM_REQ);
  localparam int CW   = $clog2(MAX_OUT + 1);
  // One extra stage covers the operand register in front of the multiplier.
  localparam int NSTG = MUL_LATENCY + 1;

  logic [IW-1:0]   ptr_q, ptr_d;
  logic [31:0]     mul_a_q, mul_a_d;
  logic [31:0]     mul_b_q, mul_b_d;
  logic [NSTG-1:0] tag_vld_q, tag_vld_d;
  logic [IW-1:0]   tag_id_q [NSTG];
  logic [IW-1:0]   tag_id_d [NSTG];
  logic [CW-1:0]   cnt_q [NUM_REQ];
  logic [CW-1:0]   cnt_d [NUM_REQ];

  logic [NUM_REQ-1:0] elig;
  logic               grant_vld;
  logic [IW-1:0]      grant_id;
  logic               rsp_any;
  logic [IW-1:0]      rsp_id;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_valid[i] && (cnt_q[i] < CW'(MAX_OUT));
    end
  end

  // First eligible requester at or after the pointer wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_vld && elig[(int'(ptr_q) + k) % NUM_REQ]) begin
        grant_vld = 1'b1;
        grant_id  = IW'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
    req_ready = '0;
    if (grant_vld) req_ready[grant_id] = 1'b1;
  end

  assign rsp_any = tag_vld_q[NSTG-1];
  assign rsp_id  = tag_id_q[NSTG-1];

  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (rsp_any) begin
      rsp_valid[rsp_id] = 1'b1;
      rsp_data          = mul_out;
    end
  end

  always_comb begin
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    ptr_d   = ptr_q;
    if (grant_vld) begin
      mul_a_d = req_a[int'(grant_id)*32 +: 32];
      mul_b_d = req_b[int'(grant_id)*32 +: 32];
      ptr_d   = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
    tag_vld_d   = {tag_vld_q[NSTG-2:0], grant_vld};
    tag_id_d[0] = grant_id;
    for (int k = 1; k < NSTG; k++) begin
      tag_id_d[k] = tag_id_q[k-1];
    end
    // Issue and response to the same requester in one cycle cancel out.
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if ((grant_vld && grant_id == IW'(i)) && !(rsp_any && rsp_id == IW'(i))) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (!(grant_vld && grant_id == IW'(i)) && (rsp_any && rsp_id == IW'(i))) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      tag_vld_q <= '0;
      for (int k = 0; k < NSTG; k++) tag_id_q[k] <= '0;
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      ptr_q     <= ptr_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      tag_vld_q <= tag_vld_d;
      for (int k = 0; k < NSTG; k++) tag_id_q[k] <= tag_id_d[k];
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign mul_a = mul_a_q;
  assign mul_b = mul_b_q;
  assign busy  = (|tag_vld_q) | (|req_valid);

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// tb/tb_fp_mult_arbiter.sv - self-checking bench for fp_mult_arbiter
module tb_fp_mult_arbiter;

  localparam int LAT = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]   rv0, rv1, rv2;
  logic [127:0] ra, rb;
  logic [3:0]   rdy0, rdy1, rdy2, rsp0, rsp1, rsp2;
  logic [31:0]  ma0, mb0, mo0, rd0;
  logic [31:0]  ma1, mb1, mo1, rd1;
  logic [31:0]  ma2, mb2, mo2, rd2;
  logic         bsy0, bsy1, bsy2;
  logic [31:0]  p0 [LAT];
  logic [31:0]  p1 [LAT];
  logic [31:0]  p2 [LAT];

  int errors = 0;
  int checks = 0;

  // Stand-in multiplier: known IEEE products for the directed cases, a fixed
  // scramble otherwise so routing mistakes show up as data differences.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40400000 && b == 32'h40000000) return 32'h40C00000;
    if (a == 32'h3FC00000 && b == 32'h3FC00000) return 32'h40100000;
    if (a == 32'h00000000 && b == 32'h7F800000) return 32'h7FFFFFFF;
    return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A5A5A;
  endfunction

  always @(posedge clk) begin
    p0[0] <= fmul(ma0, mb0);
    p1[0] <= fmul(ma1, mb1);
    p2[0] <= fmul(ma2, mb2);
    for (int k = 1; k < LAT; k++) begin
      p0[k] <= p0[k-1];
      p1[k] <= p1[k-1];
      p2[k] <= p2[k-1];
    end
  end
  assign mo0 = p0[LAT-1];
  assign mo1 = p1[LAT-1];
  assign mo2 = p2[LAT-1];

  fp_mult_arbiter #(.NUM_REQ(4), .MUL_LATENCY(LAT), .MAX_OUT(4)) u0 (
    .clk(clk), .rst(rst), .req_valid(rv0), .req_ready(rdy0), .req_a(ra), .req_b(rb),
    .mul_a(ma0), .mul_b(mb0), .mul_out(mo0), .rsp_valid(rsp0), .rsp_data(rd0), .busy(bsy0));
  fp_mult_arbiter #(.NUM_REQ(4), .MUL_LATENCY(LAT), .MAX_OUT(1)) u1 (
    .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(rdy1), .req_a(ra), .req_b(rb),
    .mul_a(ma1), .mul_b(mb1), .mul_out(mo1), .rsp_valid(rsp1), .rsp_data(rd1), .busy(bsy1));
  fp_mult_arbiter #(.NUM_REQ(4), .MUL_LATENCY(LAT), .MAX_OUT(2)) u2 (
    .clk(clk), .rst(rst), .req_valid(rv2), .req_ready(rdy2), .req_a(ra), .req_b(rb),
    .mul_a(ma2), .mul_b(mb2), .mul_out(mo2), .rsp_valid(rsp2), .rsp_data(rd2), .busy(bsy2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Outstanding-count scoreboard per instance, sampled mid-cycle.
  int mcnt [3][4];
  task automatic mon(input int d, input logic [3:0] v, input logic [3:0] r,
                     input logic [3:0] s, input int mx);
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        mcnt[d][i] = 0;
      end else begin
        if (s[i]) begin
          checks++;
          if (mcnt[d][i] == 0) begin
            errors++;
            $display("FAIL underflow u%0d req%0d: got response with %0d outstanding, required >0", d, i, mcnt[d][i]);
          end else begin
            mcnt[d][i]--;
          end
        end
        if (v[i] && r[i]) begin
          mcnt[d][i]++;
          checks++;
          if (mcnt[d][i] > mx) begin
            errors++;
            $display("FAIL overflow u%0d req%0d: got %0d outstanding, required <=%0d", d, i, mcnt[d][i], mx);
          end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, rv0, rdy0, rsp0, 4);
    mon(1, rv1, rdy1, rsp1, 1);
    mon(2, rv2, rdy2, rsp2, 2);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rv0 = '0; rv1 = '0; rv2 = '0;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } op_t;

  typedef struct {
    logic       rst_before;
    logic [3:0] rv;
    logic [3:0] rdy;
    logic [3:0] rsp;
  } cyc_t;

  op_t  ops [4];
  cyc_t tab [52];

  function automatic int oh2i(input logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return i;
    return 0;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int bad;
    rv0 = '0; rv1 = '0; rv2 = '0;
    ra = {32'h40400000, 32'h3FC00000, 32'h00000000, 32'h40400000};
    rb = {32'h40000000, 32'h3FC00000, 32'h7F800000, 32'h40000000};

    ops[0] = '{0, 32'h40400000, 32'h40000000, 32'h40C00000};
    ops[1] = '{2, 32'h3FC00000, 32'h3FC00000, 32'h40100000};
    ops[2] = '{1, 32'h00000000, 32'h7F800000, 32'h7FFFFFFF};
    ops[3] = '{3, 32'h40400000, 32'h40000000, 32'h40C00000};

    // Four requesters always valid: strict rotation, pipeline never starves.
    for (int c = 0; c < 20; c++) begin
      tab[c].rst_before = (c == 0);
      tab[c].rv  = 4'b1111;
      tab[c].rdy = 4'b0001 << (c % 4);
      tab[c].rsp = (c >= 15) ? tab[c-15].rdy : 4'b0000;
    end
    // Two requesters: each hits MAX_OUT=4 after 8 cycles and waits for returns.
    for (int c = 0; c < 32; c++) begin
      tab[20+c].rst_before = (c == 0);
      tab[20+c].rv  = 4'b0011;
      tab[20+c].rdy = (c < 8 || (c >= 16 && c < 24)) ? ((c % 2 == 0) ? 4'b0001 : 4'b0010) : 4'b0000;
      tab[20+c].rsp = (c >= 15) ? tab[20+c-15].rdy : 4'b0000;
    end

    next_cycle();
    next_cycle();
    chk("rst_mul_a", ma0, 32'h0);
    chk("rst_mul_b", mb0, 32'h0);
    chk("rst_rsp_valid", {28'h0, rsp0}, 32'h0);
    chk("rst_rsp_data", rd0, 32'h0);
    chk("rst_ready", {28'h0, rdy0}, 32'h0);
    chk("rst_busy", {31'h0, bsy0}, 32'h0);
    rst = 1'b0;

    // Single operations, one per requester.
    for (int o = 0; o < 4; o++) begin
      ra[32*ops[o].id +: 32] = ops[o].a;
      rb[32*ops[o].id +: 32] = ops[o].b;
      rv0 = 4'b0001 << ops[o].id;
      #1;
      chk($sformatf("op%0d_ready", o), {28'h0, rdy0}, {28'h0, 4'b0001 << ops[o].id});
      chk($sformatf("op%0d_busy", o), {31'h0, bsy0}, 32'h1);
      next_cycle();
      rv0 = '0;
      bad = 0;
      for (int c = 1; c < 15; c++) begin
        #1;
        if (rsp0 != 4'b0000) bad++;
        next_cycle();
      end
      chk($sformatf("op%0d_early_rsp", o), bad, 0);
      #1;
      chk($sformatf("op%0d_rsp_valid", o), {28'h0, rsp0}, {28'h0, 4'b0001 << ops[o].id});
      chk($sformatf("op%0d_rsp_data", o), rd0, ops[o].res);
      next_cycle();
      #1;
      chk($sformatf("op%0d_busy_low", o), {31'h0, bsy0}, 32'h0);
      chk($sformatf("op%0d_rsp_clear", o), {28'h0, rsp0}, 32'h0);
      next_cycle();
    end

    // Back-to-back routing: requester 2 then requester 1.
    rv0 = 4'b0100;
    #1;
    chk("route_ready2", {28'h0, rdy0}, 32'h4);
    next_cycle();
    rv0 = 4'b0010;
    #1;
    chk("route_ready1", {28'h0, rdy0}, 32'h2);
    next_cycle();
    rv0 = '0;
    repeat (13) next_cycle();
    #1;
    chk("route_rsp2_valid", {28'h0, rsp0}, 32'h4);
    chk("route_rsp2_data", rd0, 32'h40100000);
    next_cycle();
    #1;
    chk("route_rsp1_valid", {28'h0, rsp0}, 32'h2);
    chk("route_rsp1_data", rd0, 32'h7FFFFFFF);
    next_cycle();

    ra = {32'h3F800003, 32'h3F800002, 32'h3F800001, 32'h3F800000};
    rb = {32'h40000030, 32'h40000020, 32'h40000010, 32'h40000000};
    for (int i = 0; i < 52; i++) begin
      if (tab[i].rst_before) do_reset();
      rv0 = tab[i].rv;
      #1;
      chk($sformatf("rr%0d_ready", i), {28'h0, rdy0}, {28'h0, tab[i].rdy});
      chk($sformatf("rr%0d_rsp_valid", i), {28'h0, rsp0}, {28'h0, tab[i].rsp});
      if (tab[i].rsp != 4'b0000) begin
        chk($sformatf("rr%0d_rsp_data", i), rd0,
            fmul(ra[32*oh2i(tab[i].rsp) +: 32], rb[32*oh2i(tab[i].rsp) +: 32]));
      end
      next_cycle();
    end

    // MAX_OUT=1: requester 3 re-issues the cycle after each response.
    do_reset();
    for (int c = 0; c < 40; c++) begin
      rv1 = 4'b1000;
      #1;
      chk($sformatf("mo1_c%0d_ready", c), {28'h0, rdy1}, (c % 16 == 0) ? 32'h8 : 32'h0);
      chk($sformatf("mo1_c%0d_rsp", c), {28'h0, rsp1}, (c % 16 == 15) ? 32'h8 : 32'h0);
      next_cycle();
    end
    rv1 = '0;

    // MAX_OUT=2: issue coinciding with a response leaves the count at 1.
    do_reset();
    rv2 = 4'b1000;
    #1;
    chk("mo2_first_ready", {28'h0, rdy2}, 32'h8);
    next_cycle();
    rv2 = '0;
    repeat (14) next_cycle();
    rv2 = 4'b1000;
    #1;
    chk("mo2_same_rsp", {28'h0, rsp2}, 32'h8);
    chk("mo2_same_ready", {28'h0, rdy2}, 32'h8);
    next_cycle();
    #1;
    chk("mo2_second_ready", {28'h0, rdy2}, 32'h8);
    next_cycle();
    #1;
    chk("mo2_full_ready", {28'h0, rdy2}, 32'h0);
    rv2 = '0;
    next_cycle();

    // Reset with three operations in flight.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      rv0 = 4'b0111;
      #1;
      chk($sformatf("rstm_ready%0d", c), {28'h0, rdy0}, {28'h0, 4'b0001 << c});
      next_cycle();
    end
    rv0 = '0;
    repeat (5) next_cycle();
    chk("rstm_busy_before", {31'h0, bsy0}, 32'h1);
    rst = 1'b1;
    #1;
    chk("rstm_mul_a", ma0, 32'h0);
    chk("rstm_mul_b", mb0, 32'h0);
    chk("rstm_rsp_valid", {28'h0, rsp0}, 32'h0);
    chk("rstm_rsp_data", rd0, 32'h0);
    chk("rstm_busy", {31'h0, bsy0}, 32'h0);
    next_cycle();
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (rsp0 != 4'b0000 || rd0 != 32'h0) bad++;
      next_cycle();
    end
    chk("rstm_no_rsp", bad, 0);
    rv0 = 4'b1111;
    #1;
    chk("rstm_ptr_zero", {28'h0, rdy0}, 32'h1);
    next_cycle();

    // Pointer now 1: requester 3 wins over 0, then 0.
    rv0 = 4'b1001;
    #1;
    chk("skip_first", {28'h0, rdy0}, 32'h8);
    next_cycle();
    #1;
    chk("skip_second", {28'h0, rdy0}, 32'h1);
    next_cycle();
    rv0 = '0;
    repeat (20) next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
